// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard FIFO controller.
//   - Register offsets (decoded from reg_addr_i[3:2])
//   - STATUS, CTRL and DATA bit positions
//   - Helper that maps a written threshold value to its stored value
package kb_pkg;

  localparam logic [1:0] KB_DATA    = 2'd0;
  localparam logic [1:0] KB_STATUS  = 2'd1;
  localparam logic [1:0] KB_CTRL    = 2'd2;
  localparam logic [1:0] KB_OVF_CLR = 2'd3;

  localparam int unsigned KB_DATA_VALID = 31;

  localparam int unsigned KB_ST_EMPTY = 16;
  localparam int unsigned KB_ST_FULL  = 17;
  localparam int unsigned KB_ST_OVF   = 18;

  localparam int unsigned KB_CTRL_INT_EN  = 0;
  localparam int unsigned KB_CTRL_FLUSH   = 1;
  localparam int unsigned KB_CTRL_THR_LSB = 8;

  // A threshold of 0 would fire permanently; it is stored as 1 instead.
  function automatic logic [7:0] kb_thresh_fix(input logic [7:0] i_val);
    return (i_val == 8'd0) ? 8'd1 : i_val;
  endfunction

endpackage

// File: rtl/kb_sync_fifo.sv
// Synchronous FIFO for key codes.
//   clk, reset       : clock, synchronous active-high reset
//   i_push, i_data   : push request and code (dropped when full unless popping)
//   i_pop            : pop request (ignored when empty)
//   i_flush          : empty the FIFO; wins over same-cycle push/pop
//   o_head           : code at the head of the FIFO
//   o_count          : current fill level
//   o_count_next     : fill level after this cycle's edge
//   o_full, o_empty  : status flags
module kb_sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CODE_W = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [CODE_W-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [CODE_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic [CNT_W-1:0]  o_count_next,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW-1:0]     w_wr_ptr_d, w_rd_ptr_d;
  logic [CNT_W-1:0]  r_count, w_count_d;
  logic              w_pop, w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign w_push  = i_push & (~o_full | w_pop);

  always_comb begin
    w_count_d  = r_count;
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    if (i_flush) begin
      w_count_d  = '0;
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
    end else begin
      if (w_push) w_wr_ptr_d = r_wr_ptr + AW'(1);
      if (w_pop)  w_rd_ptr_d = r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      w_count_d = r_count + CNT_W'(1);
      else if (w_pop && !w_push) w_count_d = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count  <= w_count_d;
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign o_count_next = w_count_d;

endmodule

// File: rtl/kb_fifo_ctrl.sv
// Memory-mapped keyboard controller: key-code FIFO plus DATA/STATUS/CTRL/OVF_CLR
// registers and a threshold level interrupt.
//   clk, reset           : clock, synchronous active-high reset
//   key_valid_i/code_i   : new key code strobe from the front-end decoder
//   kb_req_i, kb_we_i    : register access request / write enable
//   reg_addr_i           : byte address, [3:2] selects the register
//   reg_wdata_i/mask_i   : write data and byte enables (bytes 0 and 1 used)
//   reg_rdata_o          : combinational read data
//   kb_int_o             : level interrupt; kb_int_rst_i acknowledges it
module kb_fifo_ctrl
  import kb_pkg::*;
#(
  parameter int unsigned CODE_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid_i,
  input  logic [CODE_W-1:0] key_code_i,
  input  logic              kb_req_i,
  input  logic              kb_we_i,
  input  logic [31:0]       reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  input  logic [3:0]        reg_mask_i,
  output logic [31:0]       reg_rdata_o,
  output logic              kb_int_o,
  input  logic              kb_int_rst_i
);

  logic [1:0]        w_addr;
  logic              w_wr, w_pop_req, w_flush;
  logic [CODE_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count, w_count_next;
  logic              w_full, w_empty;

  logic       r_int_en, w_int_en_d;
  logic [7:0] r_thresh, w_thresh_d;
  logic       r_ovf, w_ovf_d;
  logic       r_int, w_int_d;
  logic       w_unused;

  assign w_addr    = reg_addr_i[3:2];
  assign w_wr      = kb_req_i & kb_we_i;
  assign w_pop_req = kb_req_i & ~kb_we_i & (w_addr == KB_DATA);
  assign w_flush   = w_wr & (w_addr == KB_CTRL) & reg_mask_i[0] & reg_wdata_i[KB_CTRL_FLUSH];

  kb_sync_fifo #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (key_valid_i),
    .i_data       (key_code_i),
    .i_pop        (w_pop_req),
    .i_flush      (w_flush),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  always_comb begin
    w_int_en_d = r_int_en;
    w_thresh_d = r_thresh;
    w_ovf_d    = r_ovf;
    if (w_wr && w_addr == KB_CTRL) begin
      if (reg_mask_i[0]) w_int_en_d = reg_wdata_i[KB_CTRL_INT_EN];
      if (reg_mask_i[1]) w_thresh_d = kb_thresh_fix(reg_wdata_i[KB_CTRL_THR_LSB +: 8]);
    end
    if (w_wr && w_addr == KB_OVF_CLR && reg_mask_i[0] && reg_wdata_i[0]) w_ovf_d = 1'b0;
    // A dropped code wins over a same-cycle clear so the event is never lost.
    if (key_valid_i && w_full && !w_pop_req) w_ovf_d = 1'b1;
  end

  // Acknowledge forces one low cycle; the level re-arms if the condition holds.
  assign w_int_d = r_int_en && (32'(w_count_next) >= 32'(r_thresh)) && !(r_int && kb_int_rst_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_en <= 1'b0;
      r_thresh <= 8'd1;
      r_ovf    <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      r_int_en <= w_int_en_d;
      r_thresh <= w_thresh_d;
      r_ovf    <= w_ovf_d;
      r_int    <= w_int_d;
    end
  end

  always_comb begin
    reg_rdata_o = '0;
    case (w_addr)
      KB_DATA: begin
        if (!w_empty) begin
          reg_rdata_o[KB_DATA_VALID]  = 1'b1;
          reg_rdata_o[CODE_W-1:0]     = w_head;
        end
      end
      KB_STATUS: begin
        reg_rdata_o[CNT_W-1:0]   = w_count;
        reg_rdata_o[KB_ST_EMPTY] = w_empty;
        reg_rdata_o[KB_ST_FULL]  = w_full;
        reg_rdata_o[KB_ST_OVF]   = r_ovf;
      end
      KB_CTRL: begin
        reg_rdata_o[KB_CTRL_INT_EN]            = r_int_en;
        reg_rdata_o[KB_CTRL_THR_LSB +: 8]      = r_thresh;
      end
      default: reg_rdata_o = '0;
    endcase
  end

  assign kb_int_o = r_int;

  assign w_unused = ^{reg_addr_i[31:4], reg_addr_i[1:0], reg_wdata_i[31:16],
                      reg_wdata_i[7:2], reg_mask_i[3:2]};

endmodule

// File: tb/tb_kb_fifo_ctrl.sv
// Directed bench for kb_fifo_ctrl (CODE_W=8, DEPTH=16).
module tb_kb_fifo_ctrl;

  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_OVF = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid_i;
  logic [7:0]  key_code_i;
  logic        kb_req_i, kb_we_i;
  logic [31:0] reg_addr_i, reg_wdata_i;
  logic [3:0]  reg_mask_i;
  logic [31:0] reg_rdata_o;
  logic        kb_int_o, kb_int_rst_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kb_fifo_ctrl #(
    .CODE_W (8),
    .DEPTH  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid_i  (key_valid_i),
    .key_code_i   (key_code_i),
    .kb_req_i     (kb_req_i),
    .kb_we_i      (kb_we_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_mask_i   (reg_mask_i),
    .reg_rdata_o  (reg_rdata_o),
    .kb_int_o     (kb_int_o),
    .kb_int_rst_i (kb_int_rst_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    kb_req_i = 1'b1; kb_we_i = 1'b0; reg_addr_i = {28'h0, a, 2'b00};
    #1 d = reg_rdata_o;
    tick();
    kb_req_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v, input logic [3:0] m);
    kb_req_i = 1'b1; kb_we_i = 1'b1; reg_addr_i = {28'h0, a, 2'b00};
    reg_wdata_i = v; reg_mask_i = m;
    tick();
    kb_req_i = 1'b0; kb_we_i = 1'b0; reg_mask_i = 4'h0;
  endtask

  task automatic push(input logic [7:0] c);
    key_valid_i = 1'b1; key_code_i = c;
    tick();
    key_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (kb_int_o !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", kb_int_o); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL reset_status got %h want 00010000", d); end
    rd(A_DATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", d); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL empty_pop_status got %h want 00010000", d); end
    rd(A_CTRL, d);
    checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL reset_ctrl got %h want 00000100", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [7:0] codes [3] = '{8'h1C, 8'h32, 8'h21};
    for (int i = 0; i < 3; i++) push(codes[i]);
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL basic_status got %h want 00000003", d); end
    for (int i = 0; i < 3; i++) begin
      rd(A_DATA, d);
      checks++; if (d !== {24'h800000, codes[i]}) begin
        errors++; $display("FAIL basic_data%0d got %h want %h", i, d, {24'h800000, codes[i]});
      end
    end
    rd(A_DATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_data_empty got %h want 00000000", d); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL basic_status_end got %h want 00010000", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 1; i <= 17; i++) push(8'(i));
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0006_0010) begin errors++; $display("FAIL ovf_status got %h want 00060010", d); end
    rd(A_DATA, d);
    checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL ovf_head got %h want 80000001", d); end
    wr(A_OVF, 32'h1, 4'b0001);
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0000_000F) begin errors++; $display("FAIL ovf_clr_status got %h want 0000000f", d); end
    for (int i = 0; i < 15; i++) begin
      rd(A_DATA, d);
      checks++; if (d !== 32'h8000_0000 + 32'(i + 2)) begin
        errors++; $display("FAIL ovf_drain%0d got %h want %h", i, d, 32'h8000_0000 + 32'(i + 2));
      end
    end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL ovf_drained got %h want 00010000", d); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d, exp;
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    key_valid_i = 1'b1; key_code_i = 8'h99;
    rd(A_DATA, d);
    key_valid_i = 1'b0;
    checks++; if (d !== 32'h8000_0040) begin errors++; $display("FAIL full_pp_data got %h want 80000040", d); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0002_0010) begin errors++; $display("FAIL full_pp_status got %h want 00020010", d); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 32'h8000_0099 : 32'h8000_0041 + 32'(i);
      rd(A_DATA, d);
      checks++; if (d !== exp) begin errors++; $display("FAIL full_pp_drain%0d got %h want %h", i, d, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    // Push and pop on an empty FIFO: plain push.
    key_valid_i = 1'b1; key_code_i = 8'h77;
    rd(A_DATA, d);
    key_valid_i = 1'b0;
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL empty_pp_data got %h want 00000000", d); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL empty_pp_status got %h want 00000001", d); end
    rd(A_DATA, d);
    checks++; if (d !== 32'h8000_0077) begin errors++; $display("FAIL empty_pp_code got %h want 80000077", d); end
    // Flush beats a same-cycle push.
    push(8'h10); push(8'h11);
    key_valid_i = 1'b1; key_code_i = 8'h12;
    wr(A_CTRL, 32'h2, 4'b0001);
    key_valid_i = 1'b0;
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL flush_push_status got %h want 00010000", d); end
    rd(A_DATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL flush_push_data got %h want 00000000", d); end
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    wr(A_CTRL, 32'h0000_0301, 4'b0011);
    push(8'hA1);
    checks++; if (kb_int_o !== 1'b0) begin errors++; $display("FAIL int_push1 got %b want 0", kb_int_o); end
    push(8'hA2);
    checks++; if (kb_int_o !== 1'b0) begin errors++; $display("FAIL int_push2 got %b want 0", kb_int_o); end
    push(8'hA3);
    checks++; if (kb_int_o !== 1'b1) begin errors++; $display("FAIL int_push3 got %b want 1", kb_int_o); end
    kb_int_rst_i = 1'b1;
    tick();
    kb_int_rst_i = 1'b0;
    checks++; if (kb_int_o !== 1'b0) begin errors++; $display("FAIL int_ack_low got %b want 0", kb_int_o); end
    tick();
    checks++; if (kb_int_o !== 1'b1) begin errors++; $display("FAIL int_rearm got %b want 1", kb_int_o); end
    rd(A_DATA, d);
    checks++; if (kb_int_o !== 1'b0) begin errors++; $display("FAIL int_pop_low got %b want 0", kb_int_o); end
    tick();
    checks++; if (kb_int_o !== 1'b0) begin errors++; $display("FAIL int_stay_low got %b want 0", kb_int_o); end
  endtask

  task automatic test_ctrl_mask_flush();
    logic [31:0] d;
    wr(A_CTRL, 32'h0000_0500, 4'b0010);
    rd(A_CTRL, d);
    checks++; if (d !== 32'h0000_0501) begin errors++; $display("FAIL mask_ctrl got %h want 00000501", d); end
    push(8'h60); push(8'h61);
    checks++; if (kb_int_o !== 1'b0) begin errors++; $display("FAIL thr5_at4 got %b want 0", kb_int_o); end
    push(8'h62);
    checks++; if (kb_int_o !== 1'b1) begin errors++; $display("FAIL thr5_at5 got %b want 1", kb_int_o); end
    for (int i = 0; i < 12; i++) push(8'h70 + 8'(i));
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0006_0010) begin errors++; $display("FAIL mf_ovf_status got %h want 00060010", d); end
    wr(A_CTRL, 32'h3, 4'b0001);
    checks++; if (kb_int_o !== 1'b0) begin errors++; $display("FAIL flush_int got %b want 0", kb_int_o); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0005_0000) begin errors++; $display("FAIL flush1_status got %h want 00050000", d); end
    push(8'h81); push(8'h82); push(8'h83);
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0004_0003) begin errors++; $display("FAIL queued3_status got %h want 00040003", d); end
    wr(A_CTRL, 32'h3, 4'b0001);
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0005_0000) begin errors++; $display("FAIL flush2_status got %h want 00050000", d); end
    rd(A_CTRL, d);
    checks++; if (d !== 32'h0000_0501) begin errors++; $display("FAIL flush_ctrl_rd got %h want 00000501", d); end
    wr(A_OVF, 32'h1, 4'b0001);
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL mf_ovf_clr got %h want 00010000", d); end
    rd(A_OVF, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_reg_rd got %h want 00000000", d); end
  endtask

  task automatic test_thresh_zero();
    logic [31:0] d;
    wr(A_CTRL, 32'h0, 4'b0010);
    rd(A_CTRL, d);
    checks++; if (d !== 32'h0000_0101) begin errors++; $display("FAIL thr0_ctrl got %h want 00000101", d); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    push(8'h91); push(8'h92);
    checks++; if (kb_int_o !== 1'b1) begin errors++; $display("FAIL thr1_int got %b want 1", kb_int_o); end
    reset = 1'b1; key_valid_i = 1'b1; key_code_i = 8'h93;
    kb_req_i = 1'b1; kb_we_i = 1'b0; reg_addr_i = 32'h0;
    tick();
    reset = 1'b0; key_valid_i = 1'b0; kb_req_i = 1'b0;
    checks++; if (kb_int_o !== 1'b0) begin errors++; $display("FAIL midrst_int got %b want 0", kb_int_o); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL midrst_status got %h want 00010000", d); end
    rd(A_CTRL, d);
    checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL midrst_ctrl got %h want 00000100", d); end
  endtask

  initial begin
    reset = 1'b1; key_valid_i = 1'b0; key_code_i = 8'h0;
    kb_req_i = 1'b0; kb_we_i = 1'b0; reg_addr_i = 32'h0;
    reg_wdata_i = 32'h0; reg_mask_i = 4'h0; kb_int_rst_i = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_interrupt();
    test_ctrl_mask_flush();
    test_thresh_zero();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kb_fifo_ctrl.md
Name: kb_fifo_ctrl

Overview:
- Next-generation memory-mapped keyboard controller for the RISC-V SoC peripheral bus.
- Buffers key codes from the front-end scan/PS2 decoder in a parametrised FIFO and exposes data, status and control registers to the core.
- Raises a level interrupt to the interrupt controller when the FIFO fill level reaches a programmable threshold.

Parameters:
CODE_W, 8, key code width in bits (1..24)
DEPTH, 16, FIFO entries; power of two, 2..256
CNT_W, $clog2(DEPTH)+1, count field width; derived, not overridable

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
key_valid_i  in  1  one-cycle strobe: key_code_i holds a new code
key_code_i  in  CODE_W  key code from the front-end decoder
kb_req_i  in  1  register access request
kb_we_i  in  1  write enable; 0 = read
reg_addr_i  in  32  byte address; only [3:2] decoded
reg_wdata_i  in  32  write data
reg_mask_i  in  4  byte-enable mask for writes
reg_rdata_o  out  32  read data
kb_int_o  out  1  interrupt request, level
kb_int_rst_i  in  1  interrupt acknowledge from interrupt controller

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset clears the FIFO (count=0, pointers=0), overflow=0, int_en=0, threshold=1, kb_int_o=0.
- Register map (reg_addr_i[3:2]):
  - 0 DATA (RO, pop on read): bit31=valid, [CODE_W-1:0]=head code; reads 0 when empty.
  - 1 STATUS (RO): [CNT_W-1:0]=count, bit16=empty, bit17=full, bit18=overflow.
  - 2 CTRL (RW): bit0=int_en, bit1=flush (write-1, self-clearing, reads 0), [15:8]=threshold.
  - 3 OVF_CLR (WO): writing bit0=1 clears overflow; reads 0.
- Read path:
  - reg_rdata_o is combinational from the current state and reg_addr_i, zero latency.
  - Value is valid in the same cycle as kb_req_i.
- Pop: at the clock edge when kb_req_i=1, kb_we_i=0, addr=DATA and the FIFO is not empty. A DATA read when empty has no side effect.
- Writes: take effect at the clock edge when kb_req_i=1 and kb_we_i=1.
  - reg_mask_i[0] gates bits [7:0]; reg_mask_i[1] gates [15:8]. Other mask bits are ignored.
  - Writes to DATA and STATUS are ignored.
- Threshold:
  - A write of 0 is stored as 1.
  - A value above DEPTH is stored unchanged; the threshold interrupt then never fires.
- Push: at the clock edge when key_valid_i=1 and (not full, or a pop occurs in the same cycle).
- Overflow: key_valid_i while full with no same-cycle pop drops the code and sets the sticky overflow flag.
- Simultaneous push and pop: both are performed, count unchanged; valid on both empty and full FIFO states.
  - When empty, no pop occurs because the FIFO is empty, so this is a plain push.
- Flush:
  - Sets count=0 and pointers=0; takes priority over a same-cycle push and pop.
  - overflow is not changed by flush.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; count saturates structurally at DEPTH.
- Interrupt register update each cycle: kb_int_o <= int_en && (count_next >= threshold) && !(kb_int_o && kb_int_rst_i).
  - Acknowledge forces one low cycle.
  - The interrupt re-asserts the following cycle if the condition still holds.
  - Clearing int_en drops kb_int_o on the next edge.
- Reset mid-operation: FIFO contents are discarded; any pending pop or push in that cycle is cancelled.

Decomposition:
- Shared package kb_pkg:
  - register offsets KB_DATA=2'd0, KB_STATUS=2'd1, KB_CTRL=2'd2, KB_OVF_CLR=2'd3
  - STATUS bit positions
  - CTRL field positions
  - DATA valid bit position 31
- Sub-module kb_sync_fifo (DEPTH, CODE_W): push/pop/flush, head data, count, full, empty.
- The top level holds register decode, CTRL/overflow state and interrupt logic.

Test Plan:
1. Reset, read STATUS -> 0x0001_0000 (empty=1, count=0); read DATA -> 0x0000_0000; kb_int_o=0.
2. Push 0x1C, 0x32, 0x21; read DATA three times -> 0x8000_001C, 0x8000_0032, 0x8000_0021; fourth read -> 0; STATUS count=0.
3. DEPTH=16: push 17 codes 0x01..0x11 -> STATUS=0x0006_0010 (full, overflow, count=16); head reads 0x8000_0001; write OVF_CLR 1 -> bit18 cleared.
4. When full, key_valid_i=1 with a DATA read in the same cycle -> count stays 16; the last entry read after draining is the new code.
5. CTRL=0x0000_0301 (int_en, threshold=3), then push 3 codes -> kb_int_o rises on the edge of the third push.
   - Pulse kb_int_rst_i -> low for 1 cycle, then high again.
   - Pop one -> stays low.
6. Write CTRL with mask=4'b0010, data 0x0000_0500 -> threshold=5, int_en unchanged. Then write CTRL bit1 with 3 entries queued -> count=0, overflow preserved.
